// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ifu_state_e;
endpackage

// File: rtl/instr_mem.sv
// Word-addressed instruction memory: synchronous write, combinational read.
module instr_mem
  import ifu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [INSTR_W-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [INSTR_W-1:0]         rdata
);
  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-cycle write/read to one index returns the old word.
  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: FSM, fetch PC and output register over a valid/ready stream.
// Optional redirect ports are enabled with IFU_REDIRECT_EN.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     imem_we,
  input  logic [$clog2(DEPTH)-1:0] imem_waddr,
  input  logic [INSTR_W-1:0]       imem_wdata,
  input  logic                     instr_ready,
`ifdef IFU_REDIRECT_EN
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
`endif
  output logic                     instr_valid,
  output logic [INSTR_W-1:0]       instruction,
  output logic [31:0]              pc,
  output logic                     busy,
  output logic                     done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  ifu_state_e state, state_nxt;
  logic [31:0]        fetch_pc;
  logic               stop;
  logic [AW-1:0]      fidx, oidx;
  logic [INSTR_W-1:0] rdata;
  logic               accept, load, start_ok, redir, mem_we;
  logic [31:0]        redir_pc;

`ifdef IFU_REDIRECT_EN
  assign redir    = redirect_valid && (state != IDLE);
  assign redir_pc = redirect_pc;
`else
  assign redir    = 1'b0;
  assign redir_pc = '0;
`endif

  assign fidx     = fetch_pc[AW+1:2];
  assign oidx     = pc[AW+1:2];
  assign accept   = instr_valid && instr_ready;
  assign start_ok = start && (state != RUN);
  assign load     = (state == RUN) && !stop && (!instr_valid || instr_ready);

  instr_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .raddr (fidx),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redir) state_nxt = RUN;
    else begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (accept && oidx == LAST) state_nxt = DONE;
        DONE:    if (start) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy   = (state == RUN);
    done   = (state == DONE);
    mem_we = imem_we && (state != RUN);
  end

  // Redirect outranks start, load and stall; stop marks the last word loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      stop        <= 1'b0;
      instr_valid <= 1'b0;
      instruction <= '0;
      pc          <= '0;
    end else if (redir) begin
      fetch_pc    <= redir_pc;
      stop        <= 1'b0;
      instr_valid <= 1'b0;
    end else if (start_ok) begin
      fetch_pc <= RESET_PC;
      stop     <= 1'b0;
    end else if (load) begin
      instruction <= rdata;
      pc          <= fetch_pc;
      instr_valid <= 1'b1;
      fetch_pc    <= fetch_pc + 32'(PC_STEP);
      stop        <= (fidx == LAST);
    end else if (accept) begin
      instr_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle table, hand sequences, randomized stream model.
module tb_instr_fetch_unit;
  localparam int DEPTH = 16;
  localparam logic [31:0] ADD_W = 32'h0020_8233;
  localparam logic [31:0] SUB_W = 32'h4020_8233;

  logic        clk = 0, rst = 1, start = 0, imem_we = 0, instr_ready = 0;
  logic [3:0]  imem_waddr = 0;
  logic [31:0] imem_wdata = 0;
  logic        instr_valid, busy, done;
  logic [31:0] instruction, pc;
`ifdef IFU_REDIRECT_EN
  logic        redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
`endif

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .instr_ready(instr_ready),
`ifdef IFU_REDIRECT_EN
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`endif
    .instr_valid(instr_valid), .instruction(instruction), .pc(pc),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vecs = 0, errs = 0;
  logic [31:0] mm [DEPTH];

  typedef struct {
    logic        ready;
    logic        vld;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        busy;
    logic        done;
  } vec_t;
  vec_t tbl [21];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_all();
    for (int i = 0; i < DEPTH; i++) begin
      imem_we = 1; imem_waddr = 4'(i); imem_wdata = mm[i];
      step();
    end
    imem_we = 0;
  endtask

  // Reference: one run streams mm[0..DEPTH-1] in order with contiguous valid,
  // then reports done; junk writes during the run must not reach memory.
  task automatic run_stream(input bit rnd);
    int nexp, cyc;
    bit seen;
    nexp = 0; cyc = 0; seen = 0;
    start = 1; step(); start = 0;
    chk("run_busy", busy, 1);
    chk("run_first_valid", instr_valid, 0);
    while (!done && cyc < 500) begin
      instr_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      imem_we     = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      imem_waddr  = 4'($urandom_range(0, DEPTH - 1));
      imem_wdata  = $urandom;
      if (instr_valid) begin
        seen = 1;
        chk("stream_instr", instruction, (nexp < DEPTH) ? mm[nexp] : 32'hx);
        chk("stream_pc", pc, 32'(nexp * 4));
        if (instr_ready) nexp++;
      end else if (seen) begin
        chk("stream_bubble", instr_valid, 1);
      end
      step(); cyc++;
    end
    imem_we = 0;
    chk("stream_count", nexp, DEPTH);
    chk("stream_done", done, 1);
    chk("stream_end_valid", instr_valid, 0);
    chk("stream_end_busy", busy, 0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < DEPTH; i++) mm[i] = 32'h1000_0000 + i;
    mm[0] = ADD_W; mm[1] = SUB_W;

    tbl[0] = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    for (int i = 1; i <= 4; i++) tbl[i] = '{(i == 4), 1'b1, ADD_W, 32'h0, 1'b1, 1'b0};
    for (int i = 5; i <= 19; i++) tbl[i] = '{1'b1, 1'b1, mm[i-4], 32'((i - 4) * 4), 1'b1, 1'b0};
    tbl[20] = '{1'b0, 1'b0, mm[15], 32'h3C, 1'b0, 1'b1};

    step(); step();
    rst = 0; #1;
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    write_all();
    chk("idle_after_load", busy, 0);

    // Cycle table: first word, 3-cycle stall, then the rest of the stream.
    start = 1; step(); start = 0;
    for (int i = 0; i < 21; i++) begin
      chk($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].vld);
      chk($sformatf("tbl%0d_instr", i), instruction, tbl[i].instr);
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].done);
      instr_ready = tbl[i].ready;
      step();
    end

    // Full run without stalls: done exactly 17 edges after start; write in RUN dropped.
    instr_ready = 1;
    start = 1; step(); start = 0;
    cyc = 0;
    while (!done && cyc < 40) begin
      if (cyc == 2) begin imem_we = 1; imem_waddr = 4'd3; imem_wdata = 32'hDEAD_BEEF; end
      else imem_we = 0;
      step(); cyc++;
    end
    imem_we = 0;
    chk("done_latency", cyc, 17);
    chk("done_valid", instr_valid, 0);
    run_stream(0);

    // Randomized runs with fresh memory images.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DEPTH; i++) mm[i] = $urandom;
      write_all();
      run_stream(1);
    end

    // Reset mid-stream.
    instr_ready = 1;
    start = 1; step(); start = 0;
    step(); step(); step();
    chk("pre_rst_valid", instr_valid, 1);
    #1 rst = 1; #1;
    chk("midrst_valid", instr_valid, 0);
    chk("midrst_instr", instruction, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    step(); rst = 0; step();
    chk("post_rst_idle", busy, 0);
    run_stream(0);

`ifdef IFU_REDIRECT_EN
    instr_ready = 1;
    start = 1; step(); start = 0;
    step(); step();
    chk("redir_pre_pc", pc, 32'h4);
    redirect_valid = 1; redirect_pc = 32'h20;
    step(); redirect_valid = 0;
    chk("redir_bubble", instr_valid, 0);
    step();
    chk("redir_pc", pc, 32'h20);
    chk("redir_instr", instruction, mm[8]);
    cyc = 0;
    while (!done && cyc < 40) begin step(); cyc++; end
    chk("redir_done", done, 1);
    redirect_valid = 1; redirect_pc = 32'h0;
    step(); redirect_valid = 0;
    chk("redir_done_busy", busy, 1);
    chk("redir_done_valid", instr_valid, 0);
    step();
    chk("redir_done_pc", pc, 32'h0);
    chk("redir_done_instr", instruction, mm[0]);
    cyc = 0;
    while (!done && cyc < 40) begin step(); cyc++; end
    chk("redir_rerun_done", done, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
